// File: rtl/smi_frame_arbiter_x4_if.sv
// SMI bundle for the four-input frame arbiter: inputs A..D at index 0..3, one merged output.
// master is the arbiter's view; slave is the view of the sources and sink around it.
interface smi_frame_arbiter_x4_if #(
    parameter int FLIT_WIDTH = 16
);
    localparam int DW = FLIT_WIDTH * 8;

    logic [3:0]         smi_in_ready;
    logic [3:0][7:0]    smi_in_eofc;
    logic [3:0][DW-1:0] smi_in_data;
    logic [3:0]         smi_in_stop;
    logic               smi_out_ready;
    logic [7:0]         smi_out_eofc;
    logic [DW-1:0]      smi_out_data;
    logic               smi_out_stop;
    logic [3:0]         arb_grant;

    modport master (
        input  smi_in_ready, smi_in_eofc, smi_in_data, smi_out_stop,
        output smi_in_stop, smi_out_ready, smi_out_eofc, smi_out_data, arb_grant
    );

    modport slave (
        output smi_in_ready, smi_in_eofc, smi_in_data, smi_out_stop,
        input  smi_in_stop, smi_out_ready, smi_out_eofc, smi_out_data, arb_grant
    );
endinterface

// File: rtl/smi_frame_arbiter_x4.sv
// Four-to-one SMI merge with frame-granularity arbitration and a registered output stage.
// Round-robin by default; define SMI_FRAME_ARB_FIXED_PRIORITY_EN for fixed priority A>B>C>D.
module smi_frame_arbiter_x4 #(
    parameter int FLIT_WIDTH = 16
) (
    input logic                    clk,
    input logic                    srst,
    smi_frame_arbiter_x4_if.master bus
);
    localparam int DW = FLIT_WIDTH * 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    grant, grant_nxt;
    logic [1:0]    grant_idx, grant_idx_nxt;
    logic [1:0]    winner;
    logic [1:0]    cand;
    logic          out_ready;
    logic [7:0]    out_eofc;
    logic [DW-1:0] out_data;
    logic          out_hold;
    logic          in_xfer;
    logic          last_flit;
`ifndef SMI_FRAME_ARB_FIXED_PRIORITY_EN
    logic [1:0]    last_idx, last_idx_nxt;
`endif

    assign out_hold  = out_ready & bus.smi_out_stop;
    assign in_xfer   = (state == LOCKED) & bus.smi_in_ready[grant_idx] & ~out_hold;
    assign last_flit = (bus.smi_in_eofc[grant_idx] != 8'd0);

    // Only the granted input ever sees Stop low, and only while the output stage can move.
    assign bus.smi_in_stop   = ~grant | {4{out_hold}};
    assign bus.smi_out_ready = out_ready;
    assign bus.smi_out_eofc  = out_eofc;
    assign bus.smi_out_data  = out_data;
    assign bus.arb_grant     = grant;

    // Scan from the far end of the search order so the nearest requester is written last.
    always_comb begin
        winner = 2'd0;
        cand   = 2'd0;
`ifdef SMI_FRAME_ARB_FIXED_PRIORITY_EN
        for (int k = 3; k >= 0; k--) begin
            cand = 2'(k);
            if (bus.smi_in_ready[cand]) winner = cand;
        end
`else
        for (int k = 4; k >= 1; k--) begin
            cand = last_idx + 2'(k);
            if (bus.smi_in_ready[cand]) winner = cand;
        end
`endif
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_idx_nxt = grant_idx;
`ifndef SMI_FRAME_ARB_FIXED_PRIORITY_EN
        last_idx_nxt  = last_idx;
`endif
        case (state)
            IDLE: begin
                if (|bus.smi_in_ready) begin
                    state_nxt     = LOCKED;
                    grant_idx_nxt = winner;
                    grant_nxt     = 4'b0001 << winner;
                end
            end
            LOCKED: begin
                if (in_xfer && last_flit) begin
                    state_nxt = IDLE;
                    grant_nxt = 4'b0000;
`ifndef SMI_FRAME_ARB_FIXED_PRIORITY_EN
                    last_idx_nxt = grant_idx;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            grant     <= 4'b0000;
            grant_idx <= 2'd0;
            out_ready <= 1'b0;
`ifndef SMI_FRAME_ARB_FIXED_PRIORITY_EN
            last_idx  <= 2'd3;
`endif
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= grant_idx_nxt;
`ifndef SMI_FRAME_ARB_FIXED_PRIORITY_EN
            last_idx  <= last_idx_nxt;
`endif
            if (!out_hold) out_ready <= in_xfer;
        end
    end

    // NOTE: payload registers are deliberately not reset; out_ready qualifies them.
    always_ff @(posedge clk) begin
        if (!out_hold) begin
            out_eofc <= bus.smi_in_eofc[grant_idx];
            out_data <= bus.smi_in_data[grant_idx];
        end
    end
endmodule

// File: tb/tb_smi_frame_arbiter_x4.sv
// Self-checking bench for smi_frame_arbiter_x4: directed frame scenarios plus randomized traffic
// against a transaction-level model of sources, grant rule and output stage.
module tb_smi_frame_arbiter_x4;
    localparam int FW = 16;
    localparam int DW = FW * 8;
    localparam int CW = DW + 8;

    typedef struct packed {
        logic [7:0]    eofc;
        logic [DW-1:0] data;
    } flit_t;

    typedef struct {
        int idx;
        int cyc;
    } grant_rec_t;

    typedef struct {
        flit_t f;
        int    cyc;
    } out_rec_t;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    smi_frame_arbiter_x4_if #(.FLIT_WIDTH(FW)) bus ();

    smi_frame_arbiter_x4 #(.FLIT_WIDTH(FW)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    flit_t      src_q[4][$];
    grant_rec_t grant_log[$];
    out_rec_t   out_log[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit [3:0] en;
    int       p_present;
    int       p_stop;
    bit       force_stop;
    bit       srst_v;

    // Model: the frame lock, the last winner, and the one-deep output stage.
    bit    m_locked    = 1'b0;
    bit    m_out_valid = 1'b0;
    int    m_idx       = 0;
    int    m_last      = 3;
    flit_t m_out_flit;
    int    n_accepted  = 0;
    int    n_delivered = 0;

    logic [3:0]    prev_grant = 4'b0000;
    logic          obs_out_ready;
    logic [3:0]    obs_grant;
    logic [3:0]    obs_stop;
    logic [DW-1:0] obs_out_data;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic flit_t mk(input logic [7:0] eofc, input logic [DW-1:0] data);
        flit_t f;
        f.eofc = eofc;
        f.data = data;
        return f;
    endfunction

    function automatic int pick(input bit [3:0] req, input int last);
`ifdef SMI_FRAME_ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < 4; k++) if (req[k]) return k;
`else
        for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g[k]) return k;
        return -1;
    endfunction

    function automatic int pending();
        return src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size();
    endfunction

    task automatic push_frame(input int s, input int len);
        for (int j = 0; j < len; j++)
            src_q[s].push_back(mk((j == len - 1) ? 8'($urandom_range(1, 255)) : 8'h00, rand_data()));
    endtask

    // One clock: drive sources/sink, check at the falling edge, advance the model.
    task automatic cycle();
        flit_t    f;
        bit [3:0] rdy;
        bit       st;
        bit       hold;
        bit       xfer;
        for (int i = 0; i < 4; i++) begin
            rdy[i] = (src_q[i].size() > 0) && en[i] && ($urandom_range(99) < p_present);
            if (src_q[i].size() > 0) f = src_q[i][0];
            else f = mk(8'h00, rand_data());
            bus.smi_in_ready[i] = rdy[i];
            bus.smi_in_eofc[i]  = f.eofc;
            bus.smi_in_data[i]  = f.data;
        end
        st = force_stop || ($urandom_range(99) < p_stop);
        bus.smi_out_stop = st;
        srst = srst_v;

        @(negedge clk);
        obs_out_ready = bus.smi_out_ready;
        obs_grant     = bus.arb_grant;
        obs_stop      = bus.smi_in_stop;
        obs_out_data  = bus.smi_out_data;

        chk("arb_grant", CW'(bus.arb_grant), CW'(m_locked ? (4'b0001 << m_idx) : 4'b0000));
        chk("out_ready", CW'(bus.smi_out_ready), CW'(m_out_valid));
        if (m_out_valid) begin
            chk("out_data", CW'(bus.smi_out_data), CW'(m_out_flit.data));
            chk("out_eofc", CW'(bus.smi_out_eofc), CW'(m_out_flit.eofc));
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("stop_%0d", i), CW'(bus.smi_in_stop[i]),
                CW'(!(m_locked && m_idx == i) || (m_out_valid && st)));

        if (bus.arb_grant != 4'b0000 && prev_grant == 4'b0000)
            grant_log.push_back('{idx: onehot_idx(bus.arb_grant), cyc: cyc});
        prev_grant = bus.arb_grant;
        if (bus.smi_out_ready === 1'b1 && !st) begin
            out_log.push_back('{f: mk(bus.smi_out_eofc, bus.smi_out_data), cyc: cyc});
            n_delivered++;
        end

        hold = m_out_valid && st;
        xfer = 1'b0;
        if (srst_v) begin
            m_locked    = 1'b0;
            m_last      = 3;
            m_out_valid = 1'b0;
            for (int i = 0; i < 4; i++) src_q[i].delete();
        end else begin
            if (m_locked) begin
                if (rdy[m_idx] && !hold) begin
                    xfer = 1'b1;
                    f = src_q[m_idx].pop_front();
                    n_accepted++;
                    if (f.eofc != 8'h00) begin
                        m_locked = 1'b0;
                        m_last   = m_idx;
                    end
                end
            end else if (rdy != 4'b0000) begin
                m_idx    = pick(rdy, m_last);
                m_locked = 1'b1;
            end
            if (!hold) begin
                m_out_valid = xfer;
                if (xfer) m_out_flit = f;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        en         = 4'b0000;
        p_present  = 100;
        p_stop     = 0;
        force_stop = 1'b0;
        srst_v     = 1'b1;
        run(2);
        srst_v = 1'b0;
        grant_log.delete();
        out_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       t0;
        int       guard;
        int       exp_idx;
        flit_t    bf[4];
        logic [DW-1:0] held;

        srst              = 1'b1;
        bus.smi_in_ready  = 4'b0000;
        bus.smi_in_eofc   = '0;
        bus.smi_in_data   = '0;
        bus.smi_out_stop  = 1'b0;
        en                = 4'b0000;
        p_present         = 100;
        p_stop            = 0;
        force_stop        = 1'b0;
        srst_v            = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        cycle();
        chk("rst_out_ready", CW'(obs_out_ready), CW'(1'b0));
        chk("rst_grant", CW'(obs_grant), CW'(4'b0000));
        chk("rst_stop", CW'(obs_stop), CW'(4'b1111));

        // Single 3-flit frame on A
        do_reset();
        src_q[0].push_back(mk(8'h00, DW'(32'h11)));
        src_q[0].push_back(mk(8'h00, DW'(32'h22)));
        src_q[0].push_back(mk(8'h10, DW'(32'h33)));
        en = 4'b0001;
        t0 = cyc;
        run(8);
        chk("t1_grant_cnt", CW'(grant_log.size()), CW'(1));
        if (grant_log.size() > 0) begin
            chk("t1_grant_idx", CW'(grant_log[0].idx), CW'(0));
            chk("t1_grant_cyc", CW'(grant_log[0].cyc), CW'(t0 + 1));
        end
        chk("t1_out_cnt", CW'(out_log.size()), CW'(3));
        for (int k = 0; k < 3 && k < out_log.size(); k++) begin
            chk($sformatf("t1_out_data_%0d", k), CW'(out_log[k].f.data), CW'((k + 1) * 32'h11));
            chk($sformatf("t1_out_cyc_%0d", k), CW'(out_log[k].cyc), CW'(t0 + 2 + k));
        end
        chk("t1_grant_end", CW'(obs_grant), CW'(4'b0000));

        // All four request back-to-back 2-flit frames from reset
        do_reset();
        for (int s = 0; s < 4; s++) for (int fr = 0; fr < 4; fr++) push_frame(s, 2);
        en = 4'b1111;
        t0 = cyc;
        run(12);
        chk("t2_grant_cnt", CW'(grant_log.size()), CW'(4));
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
`ifdef SMI_FRAME_ARB_FIXED_PRIORITY_EN
            exp_idx = 0;
`else
            exp_idx = k;
`endif
            chk($sformatf("t2_grant_idx_%0d", k), CW'(grant_log[k].idx), CW'(exp_idx));
            chk($sformatf("t2_grant_cyc_%0d", k), CW'(grant_log[k].cyc), CW'(t0 + 1 + 3 * k));
        end

        // B mid-frame with the output stopped for 5 cycles
        do_reset();
        for (int j = 0; j < 4; j++) begin
            bf[j] = mk((j == 3) ? 8'h01 : 8'h00, rand_data());
            src_q[1].push_back(bf[j]);
        end
        en = 4'b0010;
        run(3);
        force_stop = 1'b1;
        held = bf[1].data;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("t3_stop_b_%0d", k), CW'(obs_stop[1]), CW'(1'b1));
            chk($sformatf("t3_held_%0d", k), CW'(obs_out_data), CW'(held));
        end
        force_stop = 1'b0;
        run(8);
        chk("t3_out_cnt", CW'(out_log.size()), CW'(4));
        for (int k = 0; k < 4 && k < out_log.size(); k++)
            chk($sformatf("t3_out_%0d", k), CW'(out_log[k].f), CW'(bf[k]));

        // Single-flit C frame while D waits
        do_reset();
        src_q[2].push_back(mk(8'h04, rand_data()));
        push_frame(3, 2);
        en = 4'b1100;
        t0 = cyc;
        run(8);
        chk("t4_grant_cnt", CW'(grant_log.size()), CW'(2));
        if (grant_log.size() > 1) begin
            chk("t4_first_idx", CW'(grant_log[0].idx), CW'(2));
            chk("t4_first_cyc", CW'(grant_log[0].cyc), CW'(t0 + 1));
            chk("t4_second_idx", CW'(grant_log[1].idx), CW'(3));
            chk("t4_second_cyc", CW'(grant_log[1].cyc), CW'(t0 + 3));
        end

        // srst during flit 2 of an A frame
        do_reset();
        push_frame(0, 4);
        en = 4'b0001;
        run(2);
        srst_v = 1'b1;
        cycle();
        srst_v = 1'b0;
        cycle();
        chk("t5_out_ready", CW'(obs_out_ready), CW'(1'b0));
        chk("t5_grant", CW'(obs_grant), CW'(4'b0000));
        chk("t5_stop", CW'(obs_stop), CW'(4'b1111));
        grant_log.delete();
        push_frame(0, 2);
        push_frame(1, 2);
        en = 4'b0011;
        run(6);
        chk("t5_grant_cnt", CW'(grant_log.size() >= 1), CW'(1'b1));
        if (grant_log.size() > 0) chk("t5_first_idx", CW'(grant_log[0].idx), CW'(0));

        // Randomized traffic with random request gaps and output backpressure
        do_reset();
        n_accepted  = 0;
        n_delivered = 0;
        for (int s = 0; s < 4; s++) for (int fr = 0; fr < 20; fr++) push_frame(s, $urandom_range(1, 4));
        en        = 4'b1111;
        p_present = 70;
        p_stop    = 30;
        run(600);
        p_present = 100;
        p_stop    = 0;
        guard     = 0;
        while ((pending() != 0 || m_locked || m_out_valid) && guard < 3000) begin
            cycle();
            guard++;
        end
        chk("rand_drain_timeout", CW'(guard >= 3000), CW'(1'b0));
        run(2);
        chk("rand_flit_count", CW'(n_delivered), CW'(n_accepted));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
